dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 256 x 8 data memory, shared between the pipeline MEM stage (CPU port) and a DMA/debug loader (DMA port). Grants one requester per cycle, drives the memory's read/write strobes, address and write data, and routes the one-cycle-latency read data back to the owner of the read. CPU has priority by default. A starvation counter guarantees DMA progress, and a lock protocol lets DMA hold the memory for a bounded burst.

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data memory arbiter, its two requesters and the memory.
// The master modport is the environment: CPU, DMA and memory. The slave modport is the arbiter.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic              dma_lock;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the shared data memory, with a bounded DMA burst lock and read-data routing.
// Define DMEM_ARB_FAIRNESS_EN to add the DMA starvation counter. Without it, the CPU has strict priority in IDLE.
module dmem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 4,
   parameter int LOCK_MAX   = 8
) (
   input logic          clk,
   input logic          reset_n,
   dmem_arbiter_if.slave bus
);

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
      $error("dmem_arbiter: STARVE_MAX out of range 1..15");
   end
   if (LOCK_MAX < 1 || LOCK_MAX > 255) begin : g_bad_lock
      $error("dmem_arbiter: LOCK_MAX out of range 1..255");
   end

   typedef enum logic [1:0] {
      IDLE,
      DMA_LOCKED,
      FORCE_REL
   } state_t;

   state_t            state;
   logic [7:0]        lock_cnt;
   logic              rd_valid;
   logic              rd_owner;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              cpu_gnt;
   logic              dma_gnt;
   logic              any_gnt;
   logic              gnt_we;
   logic              starve_hit;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_FAIRNESS_EN
   logic [3:0] starve_cnt;
   assign starve_hit = (starve_cnt == 4'(STARVE_MAX)) && bus.dma_req;
`else
   assign starve_hit = 1'b0;
`endif

   // No grant at all while reset is held, so the memory sees no strobes
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (reset_n) begin
         case (state)
            IDLE: begin
               if (bus.cpu_req && !starve_hit) cpu_gnt = 1'b1;
               else                            dma_gnt = bus.dma_req;
            end
            DMA_LOCKED: dma_gnt = bus.dma_req;
            FORCE_REL: begin
               if (bus.cpu_req) cpu_gnt = 1'b1;
               else             dma_gnt = bus.dma_req;
            end
            default: ;
         endcase
      end
   end

   assign any_gnt   = cpu_gnt | dma_gnt;
   assign gnt_we    = cpu_gnt ? bus.cpu_we    : bus.dma_we;
   assign sel_addr  = cpu_gnt ? bus.cpu_addr  : bus.dma_addr;
   assign sel_wdata = cpu_gnt ? bus.cpu_wdata : bus.dma_wdata;

   assign bus.mem_read  = any_gnt & ~gnt_we;
   assign bus.mem_write = any_gnt &  gnt_we;
   assign bus.mem_addr  = any_gnt ? sel_addr  : addr_q;
   assign bus.mem_wdata = any_gnt ? sel_wdata : wdata_q;

   assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
   assign bus.dma_gnt    = dma_gnt;
   assign bus.cpu_rvalid = rd_valid & ~rd_owner;
   assign bus.dma_rvalid = rd_valid &  rd_owner;
   assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
   assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;

   // Lock state, read-return tag and held bus values; lock_cnt counts grants already made in the burst
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         lock_cnt <= 8'd0;
         rd_valid <= 1'b0;
         rd_owner <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
`ifdef DMEM_ARB_FAIRNESS_EN
         starve_cnt <= 4'd0;
`endif
      end else begin
         rd_valid <= bus.mem_read;
         rd_owner <= dma_gnt;
         if (any_gnt) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
         end
`ifdef DMEM_ARB_FAIRNESS_EN
         if (!bus.dma_req || dma_gnt)         starve_cnt <= 4'd0;
         else if (starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
`endif
         case (state)
            IDLE: begin
               if (dma_gnt && bus.dma_lock) begin
                  lock_cnt <= 8'd1;
                  state    <= (LOCK_MAX == 1) ? FORCE_REL : DMA_LOCKED;
               end
            end
            DMA_LOCKED: begin
               if (!bus.dma_req || !bus.dma_lock) begin
                  lock_cnt <= 8'd0;
                  state    <= IDLE;
               end else begin
                  lock_cnt <= lock_cnt + 8'd1;
                  if (lock_cnt + 8'd1 == 8'(LOCK_MAX)) state <= FORCE_REL;
               end
            end
            FORCE_REL: begin
               lock_cnt <= 8'd0;
               state    <= IDLE;
            end
            default: begin
               lock_cnt <= 8'd0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour, then
// hand-written sequences for contention, the locked burst and reset during a lock.
module tb_dmem_arbiter;

   logic clk;
   logic reset_n;

`ifdef DMEM_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   dmem_arbiter #(
      .ADDR_W(8), .DATA_W(8), .STARVE_MAX(4), .LOCK_MAX(8)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: registered read, write commits at the edge, a few preset words
   logic [7:0] mem [0:255];
   always @(posedge clk) begin
      if (!reset_n) begin
         mem[8'h10] <= 8'hA5;
         mem[8'h01] <= 8'h11;
         mem[8'h02] <= 8'h22;
      end else begin
         if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
         if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   typedef struct {
      logic       cpu_req;
      logic       cpu_we;
      logic [7:0] cpu_addr;
      logic [7:0] cpu_wdata;
      logic       dma_req;
      logic       dma_we;
      logic       dma_lock;
      logic [7:0] dma_addr;
      logic [7:0] dma_wdata;
      logic       e_stall;
      logic       e_dgnt;
      logic       e_rd;
      logic       e_wr;
      logic [7:0] e_addr;
      logic [7:0] e_wdata;
      logic       e_crv;
      logic [7:0] e_crd;
      logic       e_drv;
      logic [7:0] e_drd;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   int checks = 0;
   int passes = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.cpu_req   = v.cpu_req;
      bus.cpu_we    = v.cpu_we;
      bus.cpu_addr  = v.cpu_addr;
      bus.cpu_wdata = v.cpu_wdata;
      bus.dma_req   = v.dma_req;
      bus.dma_we    = v.dma_we;
      bus.dma_lock  = v.dma_lock;
      bus.dma_addr  = v.dma_addr;
      bus.dma_wdata = v.dma_wdata;
   endtask

   task automatic idleInputs();
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_lock = 1'b0; bus.dma_addr = 8'h00; bus.dma_wdata = 8'h00;
   endtask

   task automatic cpuDrive(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
   endtask

   task automatic dmaDrive(input logic req, input logic we, input logic lock, input logic [7:0] addr, input logic [7:0] wdata);
      bus.dma_req = req; bus.dma_we = we; bus.dma_lock = lock; bus.dma_addr = addr; bus.dma_wdata = wdata;
   endtask

   initial begin
      // creq cwe caddr cwd | dreq dwe dlk daddr dwd | stall dgnt rd wr addr wdata | crv crd drv drd
      vecs[0]  = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,1'b0,8'h10,8'h00, 1'b0,8'h00,1'b0,8'h00};
      vecs[1]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h10,8'h00, 1'b1,8'hA5,1'b0,8'h00};
      vecs[2]  = '{1'b1,1'b0,8'h01,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,1'b0,8'h01,8'h00, 1'b0,8'h00,1'b0,8'h00};
      vecs[3]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b1,1'b0,8'h02,8'h00, 1'b1,8'h11,1'b0,8'h00};
      vecs[4]  = '{1'b1,1'b0,8'h01,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,1'b0,8'h01,8'h00, 1'b0,8'h00,1'b1,8'h22};
      vecs[5]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b1,1'b0,8'h02,8'h00, 1'b1,8'h11,1'b0,8'h00};
      vecs[6]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h02,8'h00, 1'b0,8'h00,1'b1,8'h22};
      vecs[7]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,1'b0,8'h80,8'h3C, 1'b0,1'b1,1'b0,1'b1,8'h80,8'h3C, 1'b0,8'h00,1'b0,8'h00};
      vecs[8]  = '{1'b1,1'b0,8'h80,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,1'b0,8'h80,8'h00, 1'b0,8'h00,1'b0,8'h00};
      vecs[9]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h80,8'h00, 1'b1,8'h3C,1'b0,8'h00};
      vecs[10] = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,1'b0,8'h40,8'h55, 1'b0,1'b0,1'b1,1'b0,8'h10,8'h00, 1'b0,8'h00,1'b0,8'h00};
      vecs[11] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,1'b0,8'h40,8'h55, 1'b0,1'b1,1'b0,1'b1,8'h40,8'h55, 1'b1,8'hA5,1'b0,8'h00};
      vecs[12] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h40,8'h55, 1'b0,8'h00,1'b0,8'h00};

      idleInputs();
      bus.cpu_req = 1'b1;
      bus.dma_req = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("rst cpu_stall", 32'(bus.cpu_stall), 32'd1);
      checkOutput("rst dma_gnt",   32'(bus.dma_gnt),   32'd0);
      checkOutput("rst mem_read",  32'(bus.mem_read),  32'd0);
      checkOutput("rst mem_write", 32'(bus.mem_write), 32'd0);
      checkOutput("rst mem_addr",  32'(bus.mem_addr),  32'd0);
      checkOutput("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
      checkOutput("rst rvalids",   32'({bus.cpu_rvalid, bus.dma_rvalid}), 32'd0);
      idleInputs();
      reset_n = 1'b1;

      // Single-cycle vectors, each applied half a cycle before its edge
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d cpu_stall", i),  32'(bus.cpu_stall),  32'(vecs[i].e_stall));
         checkOutput($sformatf("v%0d dma_gnt", i),    32'(bus.dma_gnt),    32'(vecs[i].e_dgnt));
         checkOutput($sformatf("v%0d mem_read", i),   32'(bus.mem_read),   32'(vecs[i].e_rd));
         checkOutput($sformatf("v%0d mem_write", i),  32'(bus.mem_write),  32'(vecs[i].e_wr));
         checkOutput($sformatf("v%0d mem_addr", i),   32'(bus.mem_addr),   32'(vecs[i].e_addr));
         checkOutput($sformatf("v%0d mem_wdata", i),  32'(bus.mem_wdata),  32'(vecs[i].e_wdata));
         checkOutput($sformatf("v%0d cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(vecs[i].e_crv));
         checkOutput($sformatf("v%0d cpu_rdata", i),  32'(bus.cpu_rdata),  32'(vecs[i].e_crd));
         checkOutput($sformatf("v%0d dma_rvalid", i), 32'(bus.dma_rvalid), 32'(vecs[i].e_drv));
         checkOutput($sformatf("v%0d dma_rdata", i),  32'(bus.dma_rdata),  32'(vecs[i].e_drd));
      end
      checkOutput("mem[0x40] after dma write", 32'(mem[8'h40]), 32'h55);

      // Continuous contention: 4 CPU grants then 1 forced DMA slot with fairness, else CPU only
      begin
         int s = 0;
         int dmaGrants = 0;
         for (int c = 0; c < 15; c++) begin
            logic expD;
            @(negedge clk);
            cpuDrive(1'b1, 1'b0, 8'h10, 8'h00);
            dmaDrive(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
            #1;
            expD = FAIR && (s == 4);
            checkOutput($sformatf("cont%0d dma_gnt", c),   32'(bus.dma_gnt),   32'(expD));
            checkOutput($sformatf("cont%0d cpu_stall", c), 32'(bus.cpu_stall), 32'(expD));
            checkOutput($sformatf("cont%0d mem_addr", c),  32'(bus.mem_addr),  expD ? 32'h02 : 32'h10);
            if (bus.dma_gnt) dmaGrants++;
            s = expD ? 0 : ((s < 4) ? s + 1 : 4);
         end
         checkOutput("cont dma grant total", 32'(dmaGrants), FAIR ? 32'd3 : 32'd0);
         @(negedge clk);
         idleInputs();
      end

      // Locked burst of 12 writes against a waiting CPU read: 8 DMA, CPU in FORCE_REL, DMA relocks
      begin
         int  i = 0;
         logic cpuDone = 1'b0;
         for (int c = 0; c < 13; c++) begin
            logic expD;
            logic creq;
            @(negedge clk);
            creq = (c >= 1) && !cpuDone;
            cpuDrive(creq, 1'b0, 8'h10, 8'h00);
            dmaDrive(i < 12, 1'b1, 1'b1, 8'(8'hA0 + i), 8'(8'hC0 + i));
            #1;
            expD = (c != 8);
            checkOutput($sformatf("lock%0d dma_gnt", c),    32'(bus.dma_gnt),    32'(expD));
            checkOutput($sformatf("lock%0d cpu_stall", c),  32'(bus.cpu_stall),  32'(creq && expD));
            checkOutput($sformatf("lock%0d mem_write", c),  32'(bus.mem_write),  32'(expD));
            checkOutput($sformatf("lock%0d mem_read", c),   32'(bus.mem_read),   32'(c == 8));
            checkOutput($sformatf("lock%0d cpu_rvalid", c), 32'(bus.cpu_rvalid), 32'(c == 9));
            if (c == 9) checkOutput("lock cpu_rdata", 32'(bus.cpu_rdata), 32'hA5);
            if (expD) i++;
            if (c == 8) cpuDone = 1'b1;
         end
         @(negedge clk);
         idleInputs();
         #1;
         checkOutput("lock end dma_gnt", 32'(bus.dma_gnt), 32'd0);
         for (int k = 0; k < 12; k++)
            checkOutput($sformatf("burst mem[0x%0h]", 8'hA0 + k), 32'(mem[8'(8'hA0 + k)]), 32'(8'hC0 + k));
      end

      // Reset pulse while locked with a DMA read returning
      @(negedge clk);
      dmaDrive(1'b1, 1'b0, 1'b1, 8'h02, 8'h00);
      #1;
      checkOutput("rl idle lock grant", 32'(bus.dma_gnt), 32'd1);
      @(negedge clk);
      cpuDrive(1'b1, 1'b0, 8'h10, 8'h00);
      #1;
      checkOutput("rl locked dma_gnt",   32'(bus.dma_gnt),   32'd1);
      checkOutput("rl locked cpu_stall", 32'(bus.cpu_stall), 32'd1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rl rst cpu_stall",  32'(bus.cpu_stall),  32'd1);
      checkOutput("rl rst dma_gnt",    32'(bus.dma_gnt),    32'd0);
      checkOutput("rl rst mem_read",   32'(bus.mem_read),   32'd0);
      checkOutput("rl rst mem_addr",   32'(bus.mem_addr),   32'd0);
      checkOutput("rl rst mem_wdata",  32'(bus.mem_wdata),  32'd0);
      checkOutput("rl rst dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
      checkOutput("rl rst dma_rdata",  32'(bus.dma_rdata),  32'd0);
      checkOutput("rl rst cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("rl post cpu_stall",  32'(bus.cpu_stall),  32'd0);
      checkOutput("rl post dma_gnt",    32'(bus.dma_gnt),    32'd0);
      checkOutput("rl post mem_addr",   32'(bus.mem_addr),   32'h10);
      checkOutput("rl post dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
      checkOutput("rl post cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("rl read cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
      checkOutput("rl read cpu_rdata",  32'(bus.cpu_rdata),  32'hA5);
      checkOutput("rl read dma_rvalid", 32'(bus.dma_rvalid), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
